// File: rtl/fetch_if.sv
// Instruction-fetch bus bundle between the fetch unit, instruction memory and
// the execute/control stage.
//   imem_req/imem_addr/imem_ack/imem_data : instruction-memory read channel
//   opcode/operand/pc_out/instr_valid     : issued instruction to the decoder
//   ex_ready/src_pc/cond_true             : consume strobe and next-PC control
//   halted                                : illegal opcode seen, fetch stopped
// master = fetch unit side, slave = memory/control side.
interface fetch_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned OPD_W = 8
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [OPD_W+3:0]   imem_data;
  logic [3:0]         opcode;
  logic [OPD_W-1:0]   operand;
  logic [PC_W-1:0]    pc_out;
  logic               instr_valid;
  logic               ex_ready;
  logic [1:0]         src_pc;
  logic               cond_true;
  logic               halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    output opcode, operand, pc_out, instr_valid,
    input  ex_ready, src_pc, cond_true,
    output halted
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    input  opcode, operand, pc_out, instr_valid,
    output ex_ready, src_pc, cond_true,
    input  halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch unit: reads one instruction word per fetch from instruction memory,
// presents it to the decoder until consumed, then computes the next PC
// (increment, jump, conditional branch or hold). Opcode 4'b0111 is illegal
// and parks the unit in HALT until reset.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_if master (memory read channel, issue channel, PC control)
module fetch_unit #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned OPD_W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  localparam int unsigned INSTR_W    = OPD_W + 4;
  localparam logic [3:0]  OP_ILLEGAL = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [PC_W-1:0]   r_pc;
  logic [3:0]        r_opcode;
  logic [OPD_W-1:0]  r_operand;
  logic [PC_W-1:0]   r_pc_out;

  logic [3:0]        w_fetch_op;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_pc_target;
  logic [PC_W-1:0]   w_pc_next;
  logic              w_req;
  logic              w_valid;
  logic              w_halted;
  logic [PC_W-1:0]   w_addr;

  assign w_fetch_op = bus.imem_data[INSTR_W-1 -: 4];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_valid      = 1'b0;
    w_halted     = 1'b0;
    w_addr       = '0;
    unique case (r_state)
      IDLE: begin
        w_state_next = FETCH;
      end
      FETCH: begin
        w_req  = 1'b1;
        w_addr = r_pc;
        if (bus.imem_ack) begin
          w_state_next = (w_fetch_op == OP_ILLEGAL) ? HALT : ISSUE;
        end
      end
      ISSUE: begin
        w_valid = 1'b1;
        if (bus.ex_ready) begin
          w_state_next = FETCH;
        end
      end
      HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Next-PC select; increment wraps naturally, jump target is width-cast
  always_comb begin
    w_pc_inc    = r_pc + PC_W'(1);
    w_pc_target = PC_W'(r_operand);
    w_pc_next   = r_pc;
    case (bus.src_pc)
      2'b00:   w_pc_next = w_pc_inc;
      2'b01:   w_pc_next = w_pc_target;
      2'b10:   w_pc_next = bus.cond_true ? w_pc_target : w_pc_inc;
      default: w_pc_next = r_pc;
    endcase
  end

  // Instruction register and PC; ack outside FETCH is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_opcode  <= '0;
      r_operand <= '0;
      r_pc_out  <= '0;
    end else begin
      if (r_state == FETCH && bus.imem_ack) begin
        r_opcode  <= w_fetch_op;
        r_operand <= bus.imem_data[OPD_W-1:0];
        r_pc_out  <= r_pc;
      end
      if (r_state == ISSUE && bus.ex_ready) begin
        r_pc <= w_pc_next;
      end
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = w_addr;
  assign bus.instr_valid = w_valid;
  assign bus.halted      = w_halted;
  assign bus.opcode      = r_opcode;
  assign bus.operand     = r_operand;
  assign bus.pc_out      = r_pc_out;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder with programmable ack delay,
// scoreboards for fetch addresses and issued instructions.
module tb_fetch_unit;

  logic clk;
  logic rst_n;

  fetch_if #(.PC_W(8), .OPD_W(8)) bus ();

  fetch_unit #(.PC_W(8), .OPD_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [11:0] mem [256];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          req_cyc   = 0;
  int          last_fetch_cyc = 0;
  bit          mon_en    = 0;

  logic [7:0]  exp_fetch [$];
  logic [19:0] exp_iss   [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Memory responder: ack after ack_delay extra request cycles
  initial begin
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && bus.imem_req) begin
        if (wait_cnt >= ack_delay) begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = mem[bus.imem_addr];
          wait_cnt      = 0;
        end else begin
          bus.imem_ack  = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        wait_cnt     = 0;
      end
    end
  end

  // Fetch monitor: address must match expectation every request cycle
  always @(negedge clk) begin
    if (mon_en && rst_n && bus.imem_req) begin
      req_cyc++;
      checks++;
      if (exp_fetch.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected addr=%0h", bus.imem_addr);
      end else begin
        if (bus.imem_addr !== exp_fetch[0]) begin
          errors++;
          $display("FAIL fetch_addr got=%0h exp=%0h", bus.imem_addr, exp_fetch[0]);
        end
        if (bus.imem_ack) begin
          void'(exp_fetch.pop_front());
          last_fetch_cyc = req_cyc;
          req_cyc        = 0;
        end
      end
    end
  end

  // Issue monitor: held values compared every valid cycle, popped on consume
  always @(negedge clk) begin
    if (mon_en && rst_n && bus.instr_valid) begin
      checks++;
      if (exp_iss.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected op=%0h opd=%0h pc=%0h",
                 bus.opcode, bus.operand, bus.pc_out);
      end else begin
        if ({bus.opcode, bus.operand, bus.pc_out} !== exp_iss[0]) begin
          errors++;
          $display("FAIL issue got=%05h exp=%05h",
                   {bus.opcode, bus.operand, bus.pc_out}, exp_iss[0]);
        end
        if (bus.ex_ready) void'(exp_iss.pop_front());
      end
    end
  end

  task automatic step(input logic [7:0] pc, input logic [11:0] word, input int stall,
                      input logic [1:0] src, input logic cond, input logic [7:0] nxt,
                      input int dly, output int waited);
    exp_iss.push_back({word, pc});
    exp_fetch.push_back(nxt);
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!bus.instr_valid && waited < 50);
    if (!bus.instr_valid) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout pc=%0h got=0 exp=1", pc);
      return;
    end
    repeat (stall) begin
      @(posedge clk); #1;
    end
    ack_delay     = dly;
    bus.ex_ready  = 1'b1;
    bus.src_pc    = src;
    bus.cond_true = cond;
    @(posedge clk); #1;
    // Junk control values while fetching must have no effect
    bus.ex_ready  = 1'b0;
    bus.src_pc    = 2'b01;
    bus.cond_true = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},    32'(bus.imem_req),    32'h0);
    chk({tag, "_addr"},   32'(bus.imem_addr),   32'h0);
    chk({tag, "_valid"},  32'(bus.instr_valid), 32'h0);
    chk({tag, "_op"},     32'(bus.opcode),      32'h0);
    chk({tag, "_opd"},    32'(bus.operand),     32'h0);
    chk({tag, "_pcout"},  32'(bus.pc_out),      32'h0);
    chk({tag, "_halted"}, 32'(bus.halted),      32'h0);
  endtask

  initial begin
    int w;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 12'h000;
    mem[8'h00] = 12'h105;
    mem[8'h01] = 12'h206;
    mem[8'h02] = 12'h3AA;
    mem[8'h03] = 12'h040;
    mem[8'h40] = 12'h822;
    mem[8'h41] = 12'h910;
    mem[8'h10] = 12'hAFF;
    mem[8'hFF] = 12'hB00;
    mem[8'h06] = 12'h733;

    bus.ex_ready  = 1'b0;
    bus.src_pc    = 2'b00;
    bus.cond_true = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    chk_zero("reset");

    exp_fetch.push_back(8'h00);
    mon_en = 1;
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential pair, latency and throughput
    step(8'h00, 12'h105, 0, 2'b00, 1'b0, 8'h01, 0, w);
    chk("first_issue_wait", 32'(w), 32'd2);
    step(8'h01, 12'h206, 0, 2'b00, 1'b0, 8'h02, 3, w);
    chk("back_to_back_wait", 32'(w), 32'd1);
    // Delayed ack then ex_ready stall
    step(8'h02, 12'h3AA, 2, 2'b00, 1'b0, 8'h03, 0, w);
    chk("ack_delay_req_cycles", 32'(last_fetch_cyc), 32'd4);
    // Jump and branches
    step(8'h03, 12'h040, 0, 2'b01, 1'b0, 8'h40, 0, w);
    step(8'h40, 12'h822, 0, 2'b10, 1'b0, 8'h41, 0, w);
    step(8'h41, 12'h910, 0, 2'b10, 1'b1, 8'h10, 0, w);
    // Wrap and hold
    step(8'h10, 12'hAFF, 0, 2'b01, 1'b0, 8'hFF, 0, w);
    step(8'hFF, 12'hB00, 0, 2'b00, 1'b0, 8'h00, 0, w);
    step(8'h00, 12'h105, 0, 2'b11, 1'b0, 8'h00, 0, w);
    step(8'h00, 12'h105, 0, 2'b00, 1'b0, 8'h01, 0, w);
    // Jump to the illegal opcode
    step(8'h01, 12'h206, 0, 2'b01, 1'b0, 8'h06, 0, w);

    bus.ex_ready = 1'b1;
    bus.src_pc   = 2'b00;
    repeat (5) begin
      @(posedge clk); #1;
      chk("halt_halted", 32'(bus.halted),      32'h1);
      chk("halt_valid",  32'(bus.instr_valid), 32'h0);
      chk("halt_req",    32'(bus.imem_req),    32'h0);
      chk("halt_opcode", 32'(bus.opcode),      32'h7);
    end
    bus.ex_ready = 1'b0;
    chk("halt_fetch_q_empty", 32'(exp_fetch.size()), 32'd0);
    chk("halt_iss_q_empty",   32'(exp_iss.size()),   32'd0);

    // Reset out of HALT is immediate
    #1 rst_n = 1'b0;
    #1;
    chk_zero("halt_rst");
    mon_en = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-FETCH with an ack in flight
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.imem_req && n < 10);
    chk("first_req_within_2", 32'(n <= 2), 32'h1);
    chk("first_req_addr", 32'(bus.imem_addr), 32'h0);
    chk("ack_in_flight", 32'(bus.imem_ack), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk_zero("fetch_rst");
    @(negedge clk);
    @(negedge clk);
    exp_fetch.push_back(8'h00);
    mon_en = 1;
    rst_n  = 1'b1;

    step(8'h00, 12'h105, 0, 2'b00, 1'b0, 8'h01, 0, w);
    chk("refetch_wait", 32'(w), 32'd2);
    @(negedge clk); #1;
    mon_en = 0;
    chk("end_fetch_q_empty", 32'(exp_fetch.size()), 32'd0);
    chk("end_iss_q_empty",   32'(exp_iss.size()),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
